// File: rtl/audio_dac_serializer.sv
// Left-justified DAC serializer for the WM8731: buffers stereo pairs in a small FIFO
// and shifts them out MSB-first against the codec-mastered BCLK/DACLRCK, all in CLOCK_50.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    output logic                  write_ready,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic [15:0]           underflow_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [2:0]            r_bclkSync;
    logic [2:0]            r_lrSync;
    logic [DATA_WIDTH-1:0] r_fifoLeft  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifoRight [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_rightHold;
    logic [15:0]           r_underflow;
    state_t                r_state;
    logic [BIT_W-1:0]      r_bitCnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_dacDat;

    logic                  w_lrRise;
    logic                  w_lrFall;
    logic                  w_lrEdge;
    logic                  w_bclkFall;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_loadWord;
    state_t                w_nextState;
    logic [BIT_W-1:0]      w_nextBitCnt;
    logic [DATA_WIDTH-1:0] w_nextShift;
    logic                  w_nextDacDat;

    // Two synchronizer stages plus one history stage per codec clock.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bclkSync <= '0;
            r_lrSync   <= '0;
        end else begin
            r_bclkSync <= {r_bclkSync[1:0], AUD_BCLK};
            r_lrSync   <= {r_lrSync[1:0], AUD_DACLRCK};
        end
    end

    assign w_lrRise    = r_lrSync[1] & ~r_lrSync[2];
    assign w_lrFall    = ~r_lrSync[1] & r_lrSync[2];
    assign w_lrEdge    = w_lrRise | w_lrFall;
    assign w_bclkFall  = ~r_bclkSync[1] & r_bclkSync[2];
    assign write_ready = (r_count != FULL_COUNT);
    assign w_push      = write & write_ready;
    assign w_pop       = w_lrRise & (r_count != '0);

    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_fifoLeft[r_wrPtr]  <= writedata_left;
            r_fifoRight[r_wrPtr] <= writedata_right;
        end
    end

    // A push landing on an empty FIFO during lr_rise is not bypassed to the pop.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_rightHold <= '0;
            r_underflow <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_lrRise)
                r_rightHold <= w_pop ? r_fifoRight[r_rdPtr] : '0;
            if (w_lrRise && (r_count == '0) && (r_underflow != 16'hFFFF))
                r_underflow <= r_underflow + 16'd1;
        end
    end

    always_comb begin
        w_loadWord = '0;
        if (w_pop)
            w_loadWord = r_fifoLeft[r_rdPtr];
        else if (w_lrFall)
            w_loadWord = r_rightHold;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_dacDat <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_bitCnt <= w_nextBitCnt;
            r_shift  <= w_nextShift;
            r_dacDat <= w_nextDacDat;
        end
    end

    // An LR edge always wins over a coincident bclk_fall and restarts the word.
    always_comb begin
        w_nextState  = r_state;
        w_nextBitCnt = r_bitCnt;
        w_nextShift  = r_shift;
        if (w_lrEdge) begin
            w_nextState  = SHIFT;
            w_nextBitCnt = '0;
            w_nextShift  = w_loadWord;
        end else if ((r_state == SHIFT) && w_bclkFall) begin
            if (r_bitCnt == LAST_BIT) begin
                w_nextState = IDLE;
            end else begin
                w_nextShift  = {r_shift[DATA_WIDTH-2:0], 1'b0};
                w_nextBitCnt = r_bitCnt + BIT_W'(1);
            end
        end
    end

    always_comb begin
        w_nextDacDat = r_dacDat;
        if (w_lrEdge)
            w_nextDacDat = w_loadWord[DATA_WIDTH-1];
        else if (r_state == IDLE)
            w_nextDacDat = 1'b0;
        else if (w_bclkFall)
            w_nextDacDat = (r_bitCnt == LAST_BIT) ? 1'b0 : r_shift[DATA_WIDTH-2];
    end

    assign AUD_DACDAT      = r_dacDat;
    assign underflow_count = r_underflow;

endmodule
